// File: rtl/mp_add_seq.sv
// Multi-precision serial add sequencer: streams WIDTH-bit chunks of two wide
// operands through an external combinational adder, LSB chunk first.
module mp_add_seq #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a_in,
    input  logic [WIDTH*WORDS-1:0] b_in,
    input  logic                   cin_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum_out,
    output logic                   cout_out,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDXW-1:0]             idx;
    logic                        carry;
    logic [WORDS-1:0][WIDTH-1:0] work_a;
    logic [WORDS-1:0][WIDTH-1:0] work_b;
    logic [WORDS-1:0][WIDTH-1:0] work_sum;
    logic [WORDS-1:0][WIDTH-1:0] merged_sum;
    logic                        accept;
    logic                        last_chunk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        accept     = 1'b0;
        last_chunk = 1'b0;
        // Final sum including the chunk being written at this edge, so the
        // result register never sees a partially assembled value.
        merged_sum      = work_sum;
        merged_sum[idx] = add_sum;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = work_a[idx];
                add_b   = work_b[idx];
                add_cin = carry;
                if (idx == LAST_IDX) begin
                    last_chunk = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_a   <= '0;
            work_b   <= '0;
            work_sum <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else if (accept) begin
            work_a   <= a_in;
            work_b   <= b_in;
            work_sum <= '0;
            idx      <= '0;
            carry    <= cin_in;
        end else if (state == RUN) begin
            work_sum[idx] <= add_sum;
            carry         <= add_cout;
            if (last_chunk) begin
                idx      <= '0;
                sum_out  <= merged_sum;
                cout_out <= add_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: a 4x4 instance and an 8x2 instance, each wired to a
// behavioural ripple adder; results are checked through per-instance queues.
module tb_mp_add_seq;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin_in;
    logic        busy;
    logic        done;
    logic [15:0] sum_out;
    logic        cout_out;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    logic        start8;
    logic [15:0] a_in8;
    logic [15:0] b_in8;
    logic        cin_in8;
    logic        busy8;
    logic        done8;
    logic [15:0] sum_out8;
    logic        cout_out8;
    logic [7:0]  add_a8;
    logic [7:0]  add_b8;
    logic        add_cin8;
    logic [7:0]  add_sum8;
    logic        add_cout8;

    result_t q4[$];
    result_t q8[$];
    int errors = 0;
    int checks = 0;
    logic [15:0] held_sum4 = 16'h0;
    logic        held_cout4 = 1'b0;

    assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign {add_cout8, add_sum8} = {1'b0, add_a8} + {1'b0, add_b8} + {8'b0, add_cin8};

    mp_add_seq #(.WIDTH(4), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    mp_add_seq #(.WIDTH(8), .WORDS(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .a_in(a_in8), .b_in(b_in8), .cin_in(cin_in8),
        .busy(busy8), .done(done8), .sum_out(sum_out8), .cout_out(cout_out8),
        .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8),
        .add_sum(add_sum8), .add_cout(add_cout8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic result_t model_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
        logic [16:0] s;
        result_t r;
        s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        r.sum  = s[15:0];
        r.cout = s[16];
        return r;
    endfunction

    task automatic push_expected4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        q4.push_back(model_add(a, b, cin));
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        a_in   = a;
        b_in   = b;
        cin_in = cin;
        start  = 1'b1;
        push_expected4(a, b, cin);
    endtask

    // Called at a negedge with the 4x4 instance idle; returns at a negedge.
    task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input bit scramble);
        logic [16:0] lo_mask;
        logic [16:0] partial;
        applyStimulus(a, b, cin);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                if (scramble) begin
                    a_in = ~a;
                    b_in = 16'hA5A5;
                end
            end
            lo_mask = (17'h1 << (4 * i)) - 17'h1;
            partial = ({1'b0, a} & lo_mask) + ({1'b0, b} & lo_mask) + {16'b0, cin};
            checkOutput($sformatf("add_a[%0d]", i), 32'(add_a), 32'((a >> (4 * i)) & 16'hF));
            checkOutput($sformatf("add_b[%0d]", i), 32'(add_b), 32'((b >> (4 * i)) & 16'hF));
            checkOutput($sformatf("add_cin[%0d]", i), 32'(add_cin), 32'((partial >> (4 * i)) & 17'h1));
            checkOutput($sformatf("busy_run[%0d]", i), 32'(busy), 32'd1);
            checkOutput($sformatf("done_run[%0d]", i), 32'(done), 32'd0);
            checkOutput($sformatf("sum_hold[%0d]", i), 32'(sum_out), 32'(held_sum4));
        end
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_done", 32'(busy), 32'd1);
        checkOutput("add_a_done_zero", 32'(add_a), 32'd0);
        @(negedge clk);
        checkOutput("done_after", 32'(done), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin : pop4
            result_t e;
            checkOutput("done_expected4", {31'b0, q4.size() != 0}, 32'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                checkOutput("sum_out4", 32'(sum_out), 32'(e.sum));
                checkOutput("cout_out4", 32'(cout_out), 32'(e.cout));
                held_sum4  = e.sum;
                held_cout4 = e.cout;
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin : pop8
            result_t e;
            checkOutput("done_expected8", {31'b0, q8.size() != 0}, 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                checkOutput("sum_out8", 32'(sum_out8), 32'(e.sum));
                checkOutput("cout_out8", 32'(cout_out8), 32'(e.cout));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        a_in    = 16'h0;
        b_in    = 16'h0;
        cin_in  = 1'b0;
        start8  = 1'b0;
        a_in8   = 16'h0;
        b_in8   = 16'h0;
        cin_in8 = 1'b0;

        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum_out), 32'd0);
        checkOutput("rst_cout", 32'(cout_out), 32'd0);
        checkOutput("rst_add_a", 32'(add_a), 32'd0);
        checkOutput("rst_busy8", 32'(busy8), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic operations");
        run_op4(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op4(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op4(16'h00FF, 16'h0001, 1'b0, 1'b1);

        $display("[TB] 8x2 instance");
        a_in8   = 16'h80FF;
        b_in8   = 16'h8001;
        cin_in8 = 1'b0;
        start8  = 1'b1;
        q8.push_back(model_add(16'h80FF, 16'h8001, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("add_a8[0]", 32'(add_a8), 32'hFF);
        checkOutput("add_b8[0]", 32'(add_b8), 32'h01);
        checkOutput("add_cin8[0]", 32'(add_cin8), 32'd0);
        checkOutput("done8_run0", 32'(done8), 32'd0);
        @(negedge clk);
        checkOutput("add_a8[1]", 32'(add_a8), 32'h80);
        checkOutput("add_b8[1]", 32'(add_b8), 32'h80);
        checkOutput("add_cin8[1]", 32'(add_cin8), 32'd1);
        checkOutput("done8_run1", 32'(done8), 32'd0);
        @(negedge clk);
        checkOutput("done8_pulse", 32'(done8), 32'd1);
        @(negedge clk);
        checkOutput("done8_after", 32'(done8), 32'd0);
        checkOutput("busy8_after", 32'(busy8), 32'd0);

        $display("[TB] continuous start");
        for (int k = 0; k < 18; k++) begin
            logic [15:0] opa;
            if (k > 0) @(negedge clk);
            if (k % 6 == 5) begin
                checkOutput($sformatf("cont_done[%0d]", k), 32'(done), 32'd1);
            end else begin
                checkOutput($sformatf("cont_nodone[%0d]", k), 32'(done), 32'd0);
                checkOutput($sformatf("cont_hold[%0d]", k), 32'(sum_out), 32'(held_sum4));
            end
            opa    = 16'(k * 257 + 16);
            a_in   = opa;
            b_in   = 16'h1111;
            cin_in = k[0];
            start  = 1'b1;
            if (k % 6 == 0) push_expected4(opa, 16'h1111, k[0]);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("cont_end_busy", 32'(busy), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'(sum_out), 32'd0);
        checkOutput("abort_cout", 32'(cout_out), 32'd0);
        checkOutput("abort_add_a", 32'(add_a), 32'd0);
        q4.delete();
        held_sum4  = 16'h0;
        held_cout4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_rst_nodone[%0d]", i), 32'(done), 32'd0);
        end
        run_op4(16'h1234, 16'h4321, 1'b0, 1'b0);

        checkOutput("queues_drained", 32'(q4.size() + q8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
